// File: rtl/matmul_csr_frontend_if.sv
// CPU-side req/gnt/ack word bus shared by the core and the matmul CSR window.
interface matmul_csr_frontend_if;
  logic        req;
  logic [31:0] addr;
  logic        rd;
  logic [3:0]  wr;
  logic [31:0] data_wr;
  logic        gnt;
  logic        ack;
  logic [31:0] data_rd;

  modport master (
    output req, addr, rd, wr, data_wr,
    input  gnt, ack, data_rd
  );

  modport slave (
    input  req, addr, rd, wr, data_wr,
    output gnt, ack, data_rd
  );
endinterface

// File: rtl/matmul_csr_frontend.sv
// Register window in front of the matmul controller: base addresses, start pulse,
// completion tracking from the controller's busy line, cycle counter and level IRQ.
module matmul_csr_frontend #(
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
  parameter logic [31:0] ID_VALUE  = 32'h4D4D_0202,
  parameter int          CNT_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  matmul_csr_frontend_if.slave  bus,
  output logic                  start_o,
  output logic [31:0]           addr_a_o,
  output logic [31:0]           addr_b_o,
  output logic [31:0]           addr_c_o,
  input  logic                  busy_i,
  output logic                  irq_o
);

  localparam logic [2:0] OFF_CTRL   = 3'd0;
  localparam logic [2:0] OFF_STATUS = 3'd1;
  localparam logic [2:0] OFF_ADDR_A = 3'd2;
  localparam logic [2:0] OFF_ADDR_B = 3'd3;
  localparam logic [2:0] OFF_ADDR_C = 3'd4;
  localparam logic [2:0] OFF_CYCLES = 3'd5;
  localparam logic [2:0] OFF_ID     = 3'd6;

  logic                 sel, is_wr, wr_en, rd_en;
  logic                 ctl_wr, sts_wr;
  logic                 start_req, start_ok, start_err, done_evt;
  logic [2:0]           off;
  logic [31:0]          rd_mux;
  logic [31:2]          addr_a_q, addr_b_q, addr_c_q;
  logic [CNT_WIDTH-1:0] cycles_q;
  logic                 running_q, busy_q, irq_en_q, done_q, err_q;
  logic                 ack_q, start_q, irq_q;
  logic [31:0]          data_rd_q;
  logic                 unused_addr_lsb;

  // Sub-word address bits carry no meaning on this word bus.
  assign unused_addr_lsb = ^bus.addr[1:0];

  function automatic logic [31:2] merge_bytes(input logic [31:2] old,
                                              input logic [31:0] d,
                                              input logic [3:0]  be);
    logic [31:0] t;
    t = {old, 2'b00};
    for (int b = 0; b < 4; b++) begin
      if (be[b]) t[8*b +: 8] = d[8*b +: 8];
    end
    return t[31:2];
  endfunction

  assign sel     = bus.req && (bus.addr[31:5] == BASE_ADDR[31:5]);
  assign off     = bus.addr[4:2];
  assign is_wr   = |bus.wr;
  assign wr_en   = sel && is_wr;
  assign rd_en   = sel && bus.rd && !is_wr;
  assign ctl_wr  = wr_en && (off == OFF_CTRL) && bus.wr[0];
  assign sts_wr  = wr_en && (off == OFF_STATUS) && bus.wr[0];

  assign start_req = ctl_wr && bus.data_wr[0];
  assign start_ok  = start_req && !running_q && !busy_i;
  assign start_err = start_req && (running_q || busy_i);
  // Only a falling edge of busy during our own run counts; stray edges are ignored.
  assign done_evt  = running_q && busy_q && !busy_i;

  always_comb begin
    rd_mux = '0;
    case (off)
      OFF_CTRL:   rd_mux = {30'd0, irq_en_q, 1'b0};
      OFF_STATUS: rd_mux = {29'd0, err_q, done_q, running_q | busy_i};
      OFF_ADDR_A: rd_mux = {addr_a_q, 2'b00};
      OFF_ADDR_B: rd_mux = {addr_b_q, 2'b00};
      OFF_ADDR_C: rd_mux = {addr_c_q, 2'b00};
      OFF_CYCLES: rd_mux = 32'(cycles_q);
      OFF_ID:     rd_mux = ID_VALUE;
      default:    rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      addr_a_q  <= '0;
      addr_b_q  <= '0;
      addr_c_q  <= '0;
      cycles_q  <= '0;
      running_q <= 1'b0;
      busy_q    <= 1'b0;
      irq_en_q  <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      ack_q     <= 1'b0;
      start_q   <= 1'b0;
      irq_q     <= 1'b0;
      data_rd_q <= '0;
    end else begin
      ack_q     <= sel;
      data_rd_q <= rd_en ? rd_mux : 32'd0;
      busy_q    <= busy_i;
      start_q   <= start_ok;
      irq_q     <= irq_en_q & done_q;

      if (ctl_wr) irq_en_q <= bus.data_wr[1];

      if (wr_en && off == OFF_ADDR_A) addr_a_q <= merge_bytes(addr_a_q, bus.data_wr, bus.wr);
      if (wr_en && off == OFF_ADDR_B) addr_b_q <= merge_bytes(addr_b_q, bus.data_wr, bus.wr);
      if (wr_en && off == OFF_ADDR_C) addr_c_q <= merge_bytes(addr_c_q, bus.data_wr, bus.wr);

      if (start_ok)      running_q <= 1'b1;
      else if (done_evt) running_q <= 1'b0;

      // Hardware set beats a same-edge software clear for both sticky bits.
      if (done_evt)                        done_q <= 1'b1;
      else if (start_ok)                   done_q <= 1'b0;
      else if (sts_wr && bus.data_wr[1])   done_q <= 1'b0;

      if (start_err)                       err_q <= 1'b1;
      else if (sts_wr && bus.data_wr[2])   err_q <= 1'b0;

      if (start_ok)
        cycles_q <= '0;
      else if (running_q && !done_evt && (cycles_q != '1))
        cycles_q <= cycles_q + CNT_WIDTH'(1);
    end
  end

  assign bus.gnt     = sel;
  assign bus.ack     = ack_q;
  assign bus.data_rd = data_rd_q;
  assign start_o     = start_q;
  assign irq_o       = irq_q;
  assign addr_a_o    = {addr_a_q, 2'b00};
  assign addr_b_o    = {addr_b_q, 2'b00};
  assign addr_c_o    = {addr_c_q, 2'b00};

endmodule

// File: tb/tb_matmul_csr_frontend.sv
// Directed bench: stimulus pushes expected bus read data, a negedge monitor pops on ack.
module tb_matmul_csr_frontend;

  localparam logic [31:0] BASE = 32'h4000_0000;

  typedef struct {
    string       name;
    logic [31:0] data;
  } exp_t;

  logic        clk, rst, busy, start, irq;
  logic [31:0] addr_a, addr_b, addr_c;
  int          errors = 0;
  int          checks = 0;
  exp_t        exp_q[$];

  matmul_csr_frontend_if bus ();

  matmul_csr_frontend dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .bus      (bus),
    .start_o  (start),
    .addr_a_o (addr_a),
    .addr_b_o (addr_b),
    .addr_c_o (addr_c),
    .busy_i   (busy),
    .irq_o    (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Scoreboard monitor: every ack must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && bus.ack) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_ack: got ack with data %h expected no ack", bus.data_rd);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (bus.data_rd !== e.data) begin
          errors++;
          $display("FAIL %s: got %h expected %h", e.name, bus.data_rd, e.data);
        end
      end
    end
  end

  task automatic access(input string nm, input logic [31:0] a, input logic r,
                        input logic [3:0] w, input logic [31:0] d,
                        input logic eg, input logic [31:0] ed);
    @(negedge clk);
    bus.req = 1'b1; bus.addr = a; bus.rd = r; bus.wr = w; bus.data_wr = d;
    #1;
    chk({nm, "_gnt"}, 32'(bus.gnt), 32'(eg));
    if (eg) exp_q.push_back('{nm, ed});
    @(posedge clk);
    #1;
    bus.req = 1'b0; bus.rd = 1'b0; bus.wr = 4'h0;
  endtask

  task automatic wr(input string nm, input logic [4:0] off, input logic [31:0] d,
                    input logic [3:0] be);
    access(nm, BASE + 32'(off), 1'b0, be, d, 1'b1, 32'h0);
  endtask

  task automatic rd(input string nm, input logic [4:0] off, input logic [31:0] exp);
    access(nm, BASE + 32'(off), 1'b1, 4'h0, 32'h0, 1'b1, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; busy = 1'b0;
    bus.req = 1'b0; bus.addr = '0; bus.rd = 1'b0; bus.wr = 4'h0; bus.data_wr = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_start", 32'(start), 0);
    chk("rst_irq", 32'(irq), 0);
    chk("rst_addr_a", addr_a, 0);
    chk("rst_ack", 32'(bus.ack), 0);
    rd("rst_status", 5'h04, 32'h0);
    rd("rst_ctrl", 5'h00, 32'h0);

    // Address registers, byte strobes, low bits forced to zero
    wr("wr_addr_a", 5'h08, 32'h1000_0003, 4'hF);
    chk("addr_a_out", addr_a, 32'h1000_0000);
    rd("rd_addr_a", 5'h08, 32'h1000_0000);
    wr("wr_addr_b", 5'h0C, 32'hAABB_CCDD, 4'hF);
    wr("wr_addr_b_b1", 5'h0C, 32'h0000_1100, 4'b0010);
    rd("rd_addr_b", 5'h0C, 32'hAABB_11DC);
    chk("addr_b_out", addr_b, 32'hAABB_11DC);
    wr("wr_addr_c", 5'h10, 32'h3000_0007, 4'hF);
    chk("addr_c_out", addr_c, 32'h3000_0004);

    // Full run: start with IRQ_EN, busy high 10 cycles
    wr("wr_ctrl_start", 5'h00, 32'h3, 4'hF);
    chk("start_pulse", 32'(start), 1);
    @(posedge clk); #1;
    chk("start_one_cycle", 32'(start), 0);
    busy = 1'b1;
    rd("status_running", 5'h04, 32'h1);
    rd("ctrl_irq_en", 5'h00, 32'h2);
    repeat (8) @(posedge clk);
    #1 busy = 1'b0;
    @(posedge clk); #1;
    chk("irq_lag", 32'(irq), 0);
    rd("status_done", 5'h04, 32'h2);
    chk("irq_set", 32'(irq), 1);
    rd("cycles", 5'h14, 32'd11);
    chk("no_restart", 32'(start), 0);

    // DONE W1C, then same-edge set vs clear
    wr("w1c_done", 5'h04, 32'h2, 4'h1);
    chk("irq_hold_lag", 32'(irq), 1);
    @(posedge clk); #1;
    chk("irq_cleared", 32'(irq), 0);
    wr("wr_ctrl_start2", 5'h00, 32'h3, 4'hF);
    @(posedge clk); #1 busy = 1'b1;
    repeat (3) @(posedge clk);
    #1 busy = 1'b0;
    wr("w1c_done_race", 5'h04, 32'h2, 4'h1);
    rd("status_race", 5'h04, 32'h2);
    chk("irq_race", 32'(irq), 1);
    wr("w1c_done2", 5'h04, 32'h2, 4'h1);
    rd("status_cleared", 5'h04, 32'h0);
    chk("irq_after_clear", 32'(irq), 0);

    // Start while controller busy is dropped and flags ERR
    busy = 1'b1;
    wr("wr_ctrl_busy", 5'h00, 32'h1, 4'hF);
    chk("no_start_busy", 32'(start), 0);
    @(posedge clk); #1;
    chk("no_start_busy2", 32'(start), 0);
    rd("status_err_busy", 5'h04, 32'h5);
    busy = 1'b0;
    rd("status_stray_fall", 5'h04, 32'h4);
    rd("ctrl_irq_en_off", 5'h00, 32'h0);
    wr("w1c_err", 5'h04, 32'h4, 4'h1);
    rd("status_err_clr", 5'h04, 32'h0);

    // Out-of-window, ID and reserved slot
    access("out_of_window", BASE + 32'h20, 1'b1, 4'h0, 32'h0, 1'b0, 32'h0);
    rd("id", 5'h18, 32'h4D4D_0202);
    wr("wr_id", 5'h18, 32'h0, 4'hF);
    wr("wr_rsvd", 5'h1C, 32'hFFFF_FFFF, 4'hF);
    rd("id_again", 5'h18, 32'h4D4D_0202);
    rd("rsvd", 5'h1C, 32'h0);

    // Reset in the middle of a run
    wr("wr_ctrl_start3", 5'h00, 32'h3, 4'hF);
    @(posedge clk); #1 busy = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1; busy = 1'b0;
    #1;
    chk("midrst_start", 32'(start), 0);
    chk("midrst_irq", 32'(irq), 0);
    chk("midrst_addr_a", addr_a, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    rd("post_rst_status", 5'h04, 32'h0);
    rd("post_rst_cycles", 5'h14, 32'h0);
    rd("post_rst_ctrl", 5'h00, 32'h0);
    chk("post_rst_start", 32'(start), 0);

    repeat (3) @(posedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
